inst_ram_loader: RTL and testbench
==================================

// Module: inst_ram_loader
// PURPOSE
//   Write-side counterpart of the instruction memory: receives a byte stream (host link / UART
//   receiver) and writes it as 32-bit words into the instruction RAM write port, packed in the
//   storage byte order the fetch side un-flips. Sits between the host byte receiver and the
//   instruction RAM; holds the core off (busy) while a program is being loaded.
// PARAMETERS
//   ADDR_WIDTH      8       word-address width of the instruction RAM; depth = 2**ADDR_WIDTH words
//   TIMEOUT_CYCLES  100000  max idle cycles between accepted bytes during a load before abort
// PORTS
//   clock       in   1   single clock; all logic on posedge
//   reset       in   1   synchronous, active-high reset
//   start       in   1   one-cycle request to begin a load; ignored while busy
//   byte_in     in   8   stream byte
//   byte_valid  in   1   byte_in valid
//   byte_ready  out  1   loader can accept a byte; transfer when byte_valid && byte_ready
//   wr_en       out  1   one-cycle write strobe to instruction RAM
//   wr_addr     out  32  byte address of the word written (word index << 2, bits [1:0] = 0)
//   wr_data     out  32  packed word, storage order
//   busy        out  1   load in progress (LEN_HI, LEN_LO, DATA)
//   done        out  1   sticky: last load finished; cleared by next accepted start
//   error       out  1   sticky: last load aborted (length overflow or timeout); cleared by start
//   word_count  out  16  words written in the current/last load
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, byte/word/timeout counters 0, partial word discarded.
//   - States: IDLE -start-> LEN_HI -byte-> LEN_LO -byte-> (len==0: DONE; len>2**ADDR_WIDTH:
//     ERR; else DATA) ; DATA -last byte of word len-1 accepted-> DONE ; any busy state
//     -timeout-> ERR ; DONE/ERR -start-> LEN_HI. DONE/ERR behave as IDLE w.r.t. start.
//   - Stream: 16-bit word count, MSB first, then len*4 instruction bytes, instruction MSB first.
//   - byte_ready = 1 exactly in LEN_HI, LEN_LO, DATA; 0 in IDLE/DONE/ERR and during reset.
//   - Packing: bytes b0,b1,b2,b3 of one instruction (b0 first) -> wr_data = {b3,b2,b1,b0};
//     fetch side flips back to {b0,b1,b2,b3}. Byte lane index = 2-bit counter, wraps 3->0.
//   - Write latency: wr_en, wr_addr, wr_data registered; asserted the cycle after b3 is accepted,
//     for exactly one cycle. wr_addr = {word_idx, 2'b00}, word_idx 0..len-1, zero-extended.
//   - word_count increments in the same cycle wr_en is asserted; cleared on accepted start.
//   - done (or error) asserts the cycle after the final transfer/abort cause; busy deasserts same
//     cycle. On DONE the final wr_en and done are asserted together.
//   - Timeout: counter clears on every accepted byte and on start; counts while busy; reaching
//     TIMEOUT_CYCLES -> ERR, error=1, partial word dropped, no write issued.
//   - Length overflow (len > 2**ADDR_WIDTH): ERR immediately after LEN_LO, zero writes.
//   - Last word index 2**ADDR_WIDTH-1 is legal; word index never wraps.
//   - start coincident with a byte transfer while busy: start ignored, byte accepted.
//   - reset mid-load: next edge returns to reset state; no further wr_en; RAM contents untouched.
// STRUCTURE
//   - Shared package: state encoding constants (IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR),
//     byte-flip helper function shared with the fetch-side memory.
//   - One sub-module natural: word_packer (2-bit lane counter + 32-bit shift/assemble register,
//     emits word_valid on 4th byte). FSM, counters and timeout stay in this module.
// TESTING
//   - Load len=2: bytes 00 02 | 20 08 00 05 | AC 08 00 00 -> wr_en @addr 0x0 data 0x05000820,
//     @addr 0x4 data 0x000008AC; done=1, word_count=2, error=0.
//   - len=0 (00 00) -> no wr_en, done=1 cycle after second byte, busy=0.
//   - len=0x0101 with ADDR_WIDTH=8 -> error=1, done=0, no wr_en, byte_ready=0 afterwards.
//   - Load 1 word, stall 3 bytes then idle TIMEOUT_CYCLES (set 16) -> error=1, no wr_en.
//   - byte_valid gaps of 0..5 random cycles, len=256 -> 256 writes, last addr 0x3FC, no
//     duplicate/skipped addresses; start pulse mid-load ignored.
//   - reset asserted after 6 data bytes -> all outputs 0 next cycle; new start reloads from addr 0.

Source files
------------

// File: rtl/inst_ram_loader_pkg.sv
// Shared definitions for the instruction RAM loader and the fetch-side memory:
// loader state encoding and the storage byte-order helper.
package inst_ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } load_state_t;

  // Storage order is byte-reversed relative to instruction order; the fetch side
  // applies the same function to recover the instruction.
  function automatic logic [31:0] flip_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/inst_ram_loader_word_packer.sv
// Collects four stream bytes (instruction MSB first) and presents the assembled
// word in storage order together with a one-cycle word_valid on the fourth byte.
module inst_ram_loader_word_packer
  import inst_ram_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_take,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] head;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane <= 2'd0;
      head <= 24'd0;
    end else if (byte_take) begin
      lane <= lane + 2'd1;
      head <= {head[15:0], byte_in};
    end
  end

  // The fourth byte is used directly so the word is ready in the cycle it arrives.
  assign word_valid = byte_take && (lane == 2'd3);
  assign word       = flip_bytes({head, byte_in});

endmodule

// File: rtl/inst_ram_loader.sv
// Loads a length-prefixed byte stream into the instruction RAM as 32-bit words,
// holding the core off (busy) while the program is being written.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  load_state_t state, state_next;

  logic [7:0]  len_hi;
  logic [15:0] len_words;
  logic [15:0] len_full;
  logic [31:0] timeout_cnt;
  logic        xfer;
  logic        start_ok;
  logic        timeout_hit;
  logic        data_take;
  logic        word_valid;
  logic [31:0] word;
  logic        last_word;

  assign busy       = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
  assign byte_ready = busy;
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);

  assign xfer        = byte_valid && byte_ready;
  assign start_ok    = start && !busy;
  assign len_full    = {len_hi, byte_in};
  assign data_take   = xfer && (state == ST_DATA);
  assign timeout_hit = busy && !xfer && (timeout_cnt == TIMEOUT_CYCLES - 32'd1);
  assign last_word   = word_valid && (word_count == len_words - 16'd1);

  inst_ram_loader_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok || timeout_hit),
    .byte_in    (byte_in),
    .byte_take  (data_take),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN_HI;
      ST_LEN_HI:                if (xfer) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)                 state_next = ST_DONE;
          else if ({1'b0, len_full} > MAX_WORDS) state_next = ST_ERR;
          else                                   state_next = ST_DATA;
        end
      end
      ST_DATA:                  if (last_word) state_next = ST_DONE;
      default:                  state_next = ST_IDLE;
    endcase
    // timeout_hit implies no transfer this cycle, so it never races a byte.
    if (timeout_hit) state_next = ST_ERR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi      <= 8'd0;
      len_words   <= 16'd0;
      timeout_cnt <= 32'd0;
      wr_en       <= 1'b0;
      wr_addr     <= 32'd0;
      wr_data     <= 32'd0;
      word_count  <= 16'd0;
    end else begin
      wr_en <= word_valid;
      if (word_valid) begin
        wr_addr    <= 32'({word_count[ADDR_WIDTH-1:0], 2'b00});
        wr_data    <= word;
        word_count <= word_count + 16'd1;
      end
      if (start_ok) word_count <= 16'd0;
      if (xfer && state == ST_LEN_HI) len_hi <= byte_in;
      if (xfer && state == ST_LEN_LO) len_words <= len_full;
      if (start_ok || xfer || !busy) timeout_cnt <= 32'd0;
      else                           timeout_cnt <= timeout_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed and randomized loads checked against a queue-based model of the
// expected RAM writes built straight from the byte stream.
module tb_inst_ram_loader;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        act_q[$];
  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         total = 0;
  int         bad = 0;

  inst_ram_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) act_q.push_back('{addr: wr_addr, data: wr_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected writes: word i is bytes 2+4i..2+4i+3, stored last byte in the top lane.
  task automatic build_expected();
    int len;
    exp_q.delete();
    len = (int'(stream[0]) << 8) | int'(stream[1]);
    if (len > 256) return;
    for (int i = 0; i < len; i++) begin
      wr_t w;
      w.addr = 32'(i * 4);
      w.data = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_start);
    logic ok;
    ok = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    start = with_start;
    for (int i = 0; i < 40; i++) begin
      if (byte_ready) begin
        tick(1);
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (!ok) check("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_stream(input int max_gap, input int start_at);
    for (int i = 0; i < stream.size(); i++) begin
      if (max_gap > 0) tick($urandom_range(max_gap, 0));
      if (i == start_at) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
      send_byte(stream[i], i == start_at + 7);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
    if (act_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (act_q[i].addr !== exp_q[i].addr || act_q[i].data !== exp_q[i].data) begin
          check({tag, "_addr"}, act_q[i].addr, exp_q[i].addr);
          check({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
      end
    end
  endtask

  initial begin
    int len;

    // Reset state
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    tick(1);
    check("idle_done", 32'(done), 32'd0);
    check("idle_error", 32'(error), 32'd0);

    // Known two-word program
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    build_expected();
    act_q.delete();
    pulse_start();
    check("load2_busy", 32'(busy), 32'd1);
    send_stream(0, -100);
    check("load2_done", 32'(done), 32'd1);
    check("load2_final_wr", 32'(wr_en), 32'd1);
    check("load2_busy_off", 32'(busy), 32'd0);
    tick(2);
    check("load2_count", 32'(word_count), 32'd2);
    check("load2_error", 32'(error), 32'd0);
    check("load2_n", 32'(act_q.size()), 32'd2);
    if (act_q.size() == 2) begin
      check("load2_w0", act_q[0].data, 32'h05000820);
      check("load2_a1", act_q[1].addr, 32'h4);
      check("load2_w1", act_q[1].data, 32'h000008AC);
    end

    // Zero-length load
    stream = '{8'h00, 8'h00};
    act_q.delete();
    pulse_start();
    check("len0_done_cleared", 32'(done), 32'd0);
    send_stream(0, -100);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    tick(2);
    check("len0_writes", 32'(act_q.size()), 32'd0);
    check("len0_count", 32'(word_count), 32'd0);

    // Length overflow
    stream = '{8'h01, 8'h01};
    act_q.delete();
    pulse_start();
    send_stream(0, -100);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_ready", 32'(byte_ready), 32'd0);
    tick(2);
    check("ovf_writes", 32'(act_q.size()), 32'd0);

    // Stall mid-word until timeout
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    act_q.delete();
    pulse_start();
    check("tmo_error_cleared", 32'(error), 32'd0);
    send_stream(0, -100);
    tick(TMO - 4);
    check("tmo_early_error", 32'(error), 32'd0);
    check("tmo_early_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4 * TMO && !error; i++) tick(1);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_writes", 32'(act_q.size()), 32'd0);

    // Random small loads
    for (int n = 0; n < 4; n++) begin
      len = $urandom_range(8, 1);
      stream = '{8'h00, 8'(len)};
      for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom));
      build_expected();
      act_q.delete();
      pulse_start();
      send_stream(2, -100);
      tick(2);
      check("rnd_done", 32'(done), 32'd1);
      check("rnd_count", 32'(word_count), 32'(len));
      compare_writes("rnd");
    end

    // Full-depth load with gaps and a stray start mid-stream
    stream = '{8'h01, 8'h00};
    for (int i = 0; i < 1024; i++) stream.push_back(8'($urandom));
    build_expected();
    act_q.delete();
    pulse_start();
    send_stream(5, 300);
    tick(2);
    check("full_done", 32'(done), 32'd1);
    check("full_error", 32'(error), 32'd0);
    check("full_count", 32'(word_count), 32'd256);
    if (act_q.size() > 0) check("full_last_addr", act_q[act_q.size()-1].addr, 32'h3FC);
    compare_writes("full");

    // Reset in the middle of a load, then reload from address 0
    stream = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    act_q.delete();
    pulse_start();
    send_stream(0, -100);
    reset = 1'b1;
    tick(1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    check("midrst_addr", wr_addr, 32'd0);
    check("midrst_data", wr_data, 32'd0);
    reset = 1'b0;
    tick(1);
    stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    build_expected();
    act_q.delete();
    pulse_start();
    send_stream(0, -100);
    tick(2);
    check("reload_done", 32'(done), 32'd1);
    compare_writes("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
